// File: rtl/fifo_read_adapter.sv
// fifo_read_adapter: turns the fixed-latency read port of the asynchronous FIFO
// into a stallable valid/ready stream. Read requests are credit-limited so
// every word already in flight has a guaranteed slot in the local buffer.
module fifo_read_adapter #(
  parameter int width   = 8,
  parameter int depth   = 4,
  parameter int latency = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [width-1:0]             fifo_dout,
  input  logic                         fifo_dout_valid,
  output logic                         fifo_dout_ready,
  output logic [width-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow
);

  localparam int cnt_w  = $clog2(depth + 1);
  localparam int ptr_w  = (depth > 1) ? $clog2(depth) : 1;
  localparam int pend_w = $clog2(latency + 1);
  localparam logic [ptr_w-1:0] last_ptr   = ptr_w'(depth - 1);
  localparam logic [cnt_w-1:0] full_count = cnt_w'(depth);

  logic [width-1:0]  buffer [depth];
  logic [ptr_w-1:0]  rd_ptr;
  logic [ptr_w-1:0]  wr_ptr;
  logic [latency-1:0] inflight;
  logic [pend_w-1:0] pending;
  logic [cnt_w:0]    credit_sum;
  logic              push;
  logic              pop;
  logic              accept;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_w'(1);
  endfunction

  // Number of requests still waiting for their return slot.
  always_comb begin
    pending = '0;
    for (int i = 0; i < latency; i++) begin
      pending = pending + pend_w'(inflight[i]);
    end
  end

  // Request only if every outstanding request plus the stored words still fit;
  // built from registered state only, forced low while reset is held.
  assign credit_sum      = (cnt_w+1)'(count) + (cnt_w+1)'(pending);
  assign fifo_dout_ready = !reset && (credit_sum < (cnt_w+1)'(depth));

  assign dout_valid = (count != '0);
  assign dout       = buffer[rd_ptr];
  assign push       = fifo_dout_valid;
  assign pop        = dout_valid && dout_ready;
  // A word that arrives while full is stored only if the head leaves this cycle.
  assign accept     = push && ((count != full_count) || pop);

  // Control state: pointers, occupancy, credit shift register, sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      inflight[0] <= fifo_dout_ready;
      for (int i = 1; i < latency; i++) begin
        inflight[i] <= inflight[i-1];
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (accept) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (accept && !pop) begin
        count <= count + cnt_w'(1);
      end else if (pop && !accept) begin
        count <= count - cnt_w'(1);
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage: cleared on reset so dout is never X, written on accepted pushes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        buffer[i] <= '0;
      end
    end else if (accept) begin
      buffer[wr_ptr] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Testbench for fifo_read_adapter: a FIFO model returns words two cycles after
// each sampled request, and a queue-based model of the buffer predicts every
// output on every cycle.
module tb_fifo_read_adapter;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_dout_valid = 1'b0;
  logic         fifo_dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [2:0]   count;
  logic         overflow;

  always #5 clock = ~clock;

  fifo_read_adapter #(.width(W), .depth(DEPTH), .latency(LAT)) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_dout      (fifo_dout),
    .fifo_dout_valid(fifo_dout_valid),
    .fifo_dout_ready(fifo_dout_ready),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .count          (count),
    .overflow       (overflow)
  );

  typedef struct {
    int           due;
    logic [W-1:0] d;
  } ret_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] m_q[$];       // words the buffer must hold, head first
  bit           m_ovf = 0;
  bit           m_req = 0;
  int           req_cyc[$];   // cycles of requests still holding a credit
  ret_t         ret_q[$];     // FIFO returns scheduled for future cycles
  logic [W-1:0] src_q[$];     // FIFO contents
  bit           fifo_empty = 0;
  bit           force_word = 0;
  bit           chk_en = 0;
  bit           log_en = 0;
  logic [W-1:0] got_q[$];
  int           first_acc = -1;
  int           last_acc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle, mid-period, against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("fifo_dout_ready", fifo_dout_ready, m_req);
      chk("dout_valid", dout_valid, m_q.size() != 0);
      chk("count", count, m_q.size());
      chk("overflow", overflow, m_ovf);
      if (m_q.size() != 0) chk("dout", dout, m_q[0]);
    end
    if (log_en && dout_valid && dout_ready) begin
      got_q.push_back(dout);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
  end

  // One clock cycle: drive FIFO outputs, publish model outputs, then advance
  // the model with the inputs in force at the clock edge.
  task automatic step();
    bit   pop;
    bit   full;
    ret_t r;
    while (req_cyc.size() > 0 && cyc - req_cyc[0] > LAT) void'(req_cyc.pop_front());
    m_req = !reset && (m_q.size() + req_cyc.size() < DEPTH);
    fifo_dout_valid = 1'b0;
    fifo_dout = W'($urandom);
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      fifo_dout_valid = 1'b1;
      fifo_dout = ret_q[0].d;
      void'(ret_q.pop_front());
    end else if (force_word) begin
      fifo_dout_valid = 1'b1;
    end
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_ovf = 0;
      req_cyc.delete();
    end else begin
      pop  = (m_q.size() != 0) && dout_ready;
      full = (m_q.size() == DEPTH);
      if (m_req) begin
        req_cyc.push_back(cyc);
        if (!fifo_empty && src_q.size() > 0) begin
          r.due = cyc + LAT;
          r.d   = src_q.pop_front();
          ret_q.push_back(r);
        end
      end
      if (pop) void'(m_q.pop_front());
      if (fifo_dout_valid) begin
        if (full && !pop) m_ovf = 1;
        else m_q.push_back(fifo_dout);
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    // Reset held for three edges; outputs all zero once it has taken effect.
    reset = 1'b1;
    dout_ready = 1'b0;
    step();
    chk_en = 1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_dout_ready", fifo_dout_ready, 0);
    step();
    step();
    for (int i = 1; i <= 32; i++) src_q.push_back(W'(i));
    reset = 1'b0;
    #1;
    chk("post_rst_fifo_dout_ready", fifo_dout_ready, 1);
    chk("post_rst_count", count, 0);
    chk("post_rst_dout", dout, 0);

    // Streaming 0x01..0x20 with the consumer always ready.
    dout_ready = 1'b1;
    log_en = 1;
    for (int i = 0; i < 40; i++) step();
    log_en = 0;
    chk("stream_words", got_q.size(), 32);
    for (int i = 0; i < got_q.size(); i++) chk("stream_data", got_q[i], i + 1);
    chk("stream_first_cycle", first_acc, 6);
    chk("stream_gap_free", last_acc - first_acc, 31);
    chk("stream_overflow", overflow, 0);

    // Downstream stall of ten cycles with the FIFO never empty.
    for (int i = 0; i < 64; i++) src_q.push_back(W'(8'h21 + i));
    for (int i = 0; i < 6; i++) step();
    dout_ready = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("stall_count", count, 4);
    chk("stall_fifo_dout_ready", fifo_dout_ready, 0);
    chk("stall_dout_valid", dout_valid, 1);
    step();
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // FIFO empty: requests keep going out but nothing returns.
    src_q.delete();
    for (int i = 0; i < 6; i++) step();
    fifo_empty = 1;
    for (int i = 0; i < 8; i++) begin
      chk("empty_count", count, 0);
      chk("empty_dout_valid", dout_valid, 0);
      chk("empty_fifo_dout_ready", fifo_dout_ready, 1);
      step();
    end
    fifo_empty = 0;

    // Single-word toggling: one word stored, push and pop every cycle.
    for (int i = 0; i < 40; i++) src_q.push_back(W'($urandom));
    for (int i = 0; i < 25; i++) begin
      if (i >= 4 && i < 24) chk("toggle_count", count, 1);
      step();
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) fifo_empty = !fifo_empty;
      while (src_q.size() < 4) src_q.push_back(W'($urandom));
      step();
    end
    fifo_empty = 0;

    // Overflow: fill the buffer, then force words with no pop.
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("ovf_pre_count", count, 4);
    chk("ovf_pre_flag", overflow, 0);
    force_word = 1;
    step();
    step();
    force_word = 0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    for (int i = 0; i < 3; i++) step();
    chk("ovf_sticky", overflow, 1);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("ovf_sticky_after_drain", overflow, 1);

    // Reset in the middle of traffic, then a clean restart.
    for (int i = 0; i < 10; i++) begin
      dout_ready = ($urandom_range(0, 1) != 0);
      step();
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    #1;
    chk("midrst_overflow", overflow, 0);
    chk("midrst_count", count, 0);
    chk("midrst_fifo_dout_ready", fifo_dout_ready, 1);
    dout_ready = 1'b1;
    for (int i = 0; i < 40; i++) step();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
